// File: rtl/por_rst_seq_if.sv
// ---------------------------------------------------------------------------
// por_rst_seq_if
//
// Bundles the POR status inputs, the test/debug controls and the staged
// reset outputs of por_rst_seq.  The oscillator clock and the power-up reset
// stay plain ports on the sequencer itself.
//
//   por_unbuf           POR pulse from the POR digital section (osc_ck domain)
//   por_timed_out       POR one-shot finished (osc_ck domain)
//   force_short_oneshot selects the short inter-stage gap (static during test)
//   ext_rstb            asynchronous active-low external reset request
//   rst_stgb[N_STG]     staged active-low domain resets, bit 0 released first
//   seq_done            every stage has been released
//   ext_rst_cnt[4]      saturating count of external-reset aborts (debug)
//
// The master modport is the side that drives the POR status and controls
// (the POR digital section or a testbench); the slave modport is the
// sequencer.
// ---------------------------------------------------------------------------
interface por_rst_seq_if #(
    parameter int N_STG = 4
);
    logic             por_unbuf;
    logic             por_timed_out;
    logic             force_short_oneshot;
    logic             ext_rstb;
    logic [N_STG-1:0] rst_stgb;
    logic             seq_done;
    logic [3:0]       ext_rst_cnt;

    modport master (
        output por_unbuf,
        output por_timed_out,
        output force_short_oneshot,
        output ext_rstb,
        input  rst_stgb,
        input  seq_done,
        input  ext_rst_cnt
    );

    modport slave (
        input  por_unbuf,
        input  por_timed_out,
        input  force_short_oneshot,
        input  ext_rstb,
        output rst_stgb,
        output seq_done,
        output ext_rst_cnt
    );
endinterface

// File: rtl/por_rst_seq.sv
// ---------------------------------------------------------------------------
// por_rst_seq
//
// Downstream stage of the power-on-reset digital section.  Once the POR
// one-shot has finished (por_timed_out=1, por_unbuf=0) and no external reset
// is requested, the N_STG active-low domain resets are released one at a
// time, bit 0 first, with gap_lim oscillator cycles between releases.  Any
// loss of that condition drops every stage back into reset in one cycle.
//
// Ports:
//   osc_ck      RC oscillator clock, every flop is rising-edge
//   pwup_filt   filtered power-up reset, asynchronous active-low
//   bus         por_rst_seq_if.slave: POR status, controls, staged resets,
//               seq_done and the external-abort debug counter
//
// Timing: with E the edge that moves HOLD->RELEASE, rst_stgb[k] rises at
// edge E+(k+1)*gap_lim and seq_done rises together with the last stage.
// ---------------------------------------------------------------------------
module por_rst_seq #(
    parameter int N_STG     = 4,
    parameter int GAP_W     = 5,
    parameter int GAP       = 8,
    parameter int GAP_SHORT = 2
) (
    input  logic         osc_ck,
    input  logic         pwup_filt,
    por_rst_seq_if.slave bus
);

    localparam int IDX_W = (N_STG > 1) ? $clog2(N_STG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STG - 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        DONE
    } state_t;

    state_t           state_q;
    logic             extS1_q;
    logic             extS2_q;
    logic [GAP_W-1:0] gapCnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [N_STG-1:0] rstStgb_q;
    logic             seqDone_q;
    logic [3:0]       extRstCnt_q;

    logic             goCond;
    logic             abortCond;
    logic [GAP_W-1:0] gapLim;
    logic             gapExpired;
    logic [3:0]       extRstCnt_d;

    // Release/abort qualifiers.  gapLim is re-evaluated every cycle, so a
    // mode change mid-gap takes effect immediately; the >= compare makes a
    // counter that is already past a freshly shortened limit release on the
    // very next edge instead of wrapping around.
    always_comb begin
        goCond      = bus.por_timed_out & ~bus.por_unbuf & extS2_q;
        abortCond   = ~bus.por_timed_out | bus.por_unbuf | ~extS2_q;
        gapLim      = bus.force_short_oneshot ? GAP_W'(GAP_SHORT) : GAP_W'(GAP);
        gapExpired  = (gapCnt_q >= (gapLim - GAP_W'(1)));
        extRstCnt_d = extRstCnt_q;
        if (!extS2_q && (extRstCnt_q != 4'hF)) begin
            extRstCnt_d = extRstCnt_q + 4'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous external reset request.
    // Both flops clear to 0 so that nothing is released until the request
    // has been seen high for two full cycles after power-up.
    always_ff @(posedge osc_ck or negedge pwup_filt) begin
        if (!pwup_filt) begin
            extS1_q <= 1'b0;
            extS2_q <= 1'b0;
        end else begin
            extS1_q <= bus.ext_rstb;
            extS2_q <= extS1_q;
        end
    end

    // Sequencer FSM with registered outputs.  Abort is tested before the gap
    // counter so that a release coinciding with loss of the go condition is
    // suppressed, and every abort clears all stages at once.  Only aborts
    // seen with the synchronized external request low advance the debug
    // counter (extRstCnt_d already folds in that condition and saturation).
    always_ff @(posedge osc_ck or negedge pwup_filt) begin
        if (!pwup_filt) begin
            state_q     <= HOLD;
            gapCnt_q    <= '0;
            idx_q       <= '0;
            rstStgb_q   <= '0;
            seqDone_q   <= 1'b0;
            extRstCnt_q <= 4'd0;
        end else begin
            case (state_q)
                HOLD: begin
                    rstStgb_q <= '0;
                    seqDone_q <= 1'b0;
                    if (goCond) begin
                        state_q  <= RELEASE;
                        gapCnt_q <= '0;
                        idx_q    <= '0;
                    end
                end

                RELEASE: begin
                    if (abortCond) begin
                        state_q     <= HOLD;
                        rstStgb_q   <= '0;
                        seqDone_q   <= 1'b0;
                        gapCnt_q    <= '0;
                        idx_q       <= '0;
                        extRstCnt_q <= extRstCnt_d;
                    end else if (gapExpired) begin
                        rstStgb_q[idx_q] <= 1'b1;
                        gapCnt_q         <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q   <= DONE;
                            seqDone_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        gapCnt_q <= gapCnt_q + GAP_W'(1);
                    end
                end

                DONE: begin
                    rstStgb_q <= '1;
                    seqDone_q <= 1'b1;
                    if (abortCond) begin
                        state_q     <= HOLD;
                        rstStgb_q   <= '0;
                        seqDone_q   <= 1'b0;
                        gapCnt_q    <= '0;
                        idx_q       <= '0;
                        extRstCnt_q <= extRstCnt_d;
                    end
                end

                default: begin
                    state_q   <= HOLD;
                    rstStgb_q <= '0;
                    seqDone_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_stgb    = rstStgb_q;
    assign bus.seq_done    = seqDone_q;
    assign bus.ext_rst_cnt = extRstCnt_q;

endmodule

// File: tb/tb_por_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_por_rst_seq
//
// Scoreboard bench for por_rst_seq.  Each sequence run decides its go edge
// and abort edge up front, and a release-schedule model derived from the
// timing rules (stage k at E+(k+1)*gap, abort clears everything, external
// aborts counted and saturating) pushes every visible output change into a
// queue.  An independent monitor pops an entry whenever the DUT outputs
// change and compares edge number and values.
// ---------------------------------------------------------------------------
module tb_por_rst_seq;

    localparam int N_STG     = 4;
    localparam int GAP_W     = 5;
    localparam int GAP       = 8;
    localparam int GAP_SHORT = 2;

    localparam int K_POR  = 0;
    localparam int K_UNB  = 1;
    localparam int K_EXT  = 2;
    localparam int K_EXTR = 3;

    typedef struct {
        int               edgeNum;
        logic [N_STG-1:0] rst;
        logic             done;
        logic [3:0]       cnt;
    } ev_t;

    logic osc_ck;
    logic pwup_filt;
    int   edgeCnt = 0;
    int   nChecks = 0;
    int   nBad    = 0;

    ev_t  expQ[$];

    logic [N_STG-1:0] mRst;
    logic             mDone;
    int               mCnt;
    logic [N_STG-1:0] lastRst;
    logic             lastDone;
    int               lastCnt;

    por_rst_seq_if #(.N_STG(N_STG)) bus ();

    por_rst_seq #(
        .N_STG    (N_STG),
        .GAP_W    (GAP_W),
        .GAP      (GAP),
        .GAP_SHORT(GAP_SHORT)
    ) dut (
        .osc_ck   (osc_ck),
        .pwup_filt(pwup_filt),
        .bus      (bus)
    );

    // Free-running oscillator and a count of rising edges, used as the
    // common time base of the schedule model and the monitor.
    initial osc_ck = 1'b0;
    always #5 osc_ck = ~osc_ck;

    always @(posedge osc_ck) edgeCnt <= edgeCnt + 1;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edgeCnt);
        end
    endtask

    // Record the model's output state as an expected event if it is visible.
    task automatic pushEv(input int e);
        ev_t ev;
        if (mRst !== lastRst || mDone !== lastDone || mCnt != lastCnt) begin
            ev.edgeNum = e;
            ev.rst     = mRst;
            ev.done    = mDone;
            ev.cnt     = 4'(mCnt);
            expQ.push_back(ev);
            lastRst  = mRst;
            lastDone = mDone;
            lastCnt  = mCnt;
        end
    endtask

    // Schedule model for one run: go at edge eEdge, stages every gl edges,
    // everything cleared at aEdge (a release landing on aEdge loses).
    task automatic planSeq(input int eEdge, input int gl, input int aEdge, input bit extCause, input bit porReset);
        int rel;
        for (int k = 0; k < N_STG; k++) begin
            rel = eEdge + (k + 1) * gl;
            if (rel < aEdge) begin
                mRst  = N_STG'((1 << (k + 1)) - 1);
                mDone = (k == N_STG - 1);
                pushEv(rel);
            end
        end
        if (porReset) mCnt = 0;
        else if (extCause && mCnt < 15) mCnt++;
        mRst  = '0;
        mDone = 1'b0;
        pushEv(aEdge);
    endtask

    // Park at the falling edge just before rising edge n, so inputs driven
    // on return are sampled at edge n.
    task automatic waitToEdge(input int n);
        if (edgeCnt >= n) begin
            nChecks++;
            nBad++;
            $display("[TB] FAIL schedule: at edge %0d required to be before edge %0d", edgeCnt, n);
        end
        while (edgeCnt < n - 1) @(negedge osc_ck);
    endtask

    // One sequence run from HOLD: go two edges ahead, then an abort of the
    // chosen kind driven off edges after go; leaves the DUT in HOLD.
    task automatic applyStimulus(input bit shortMode, input int kind, input int off);
        int gl, e, d, a, e2, a2, endEdge;
        gl = shortMode ? GAP_SHORT : GAP;
        bus.force_short_oneshot = shortMode;
        e = edgeCnt + 2;
        d = e + off;
        a = (kind == K_EXT || kind == K_EXTR) ? d + 2 : d;
        planSeq(e, gl, a, (kind == K_EXT || kind == K_EXTR), 1'b0);
        waitToEdge(e);
        bus.por_timed_out = 1'b1;
        bus.por_unbuf     = 1'b0;
        waitToEdge(d);
        case (kind)
            K_POR: begin
                bus.por_timed_out = 1'b0;
                endEdge = d + 3;
            end
            K_UNB: begin
                bus.por_unbuf = 1'b1;
                waitToEdge(d + 1);
                bus.por_unbuf     = 1'b0;
                bus.por_timed_out = 1'b0;
                endEdge = d + 3;
            end
            K_EXT: begin
                bus.ext_rstb = 1'b0;
                waitToEdge(d + 3);
                bus.por_timed_out = 1'b0;
                waitToEdge(d + 5);
                bus.ext_rstb = 1'b1;
                endEdge = d + 8;
            end
            default: begin
                bus.ext_rstb = 1'b0;
                waitToEdge(d + 5);
                bus.ext_rstb = 1'b1;
                e2 = d + 7;
                a2 = e2 + N_STG * gl + 3;
                planSeq(e2, gl, a2, 1'b0, 1'b0);
                waitToEdge(a2);
                bus.por_timed_out = 1'b0;
                endEdge = a2 + 3;
            end
        endcase
        waitToEdge(endEdge);
    endtask

    // Monitor: every change of the DUT outputs must match the next
    // scheduled event, both in edge number and in value.
    initial begin : monitor
        ev_t              ev;
        logic [N_STG-1:0] pRst;
        logic             pDone;
        logic [3:0]       pCnt;
        pRst  = '0;
        pDone = 1'b0;
        pCnt  = 4'd0;
        @(posedge osc_ck);
        forever begin
            @(negedge osc_ck);
            if ({bus.rst_stgb, bus.seq_done, bus.ext_rst_cnt} !== {pRst, pDone, pCnt}) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nBad++;
                    $display("[TB] FAIL unexpected_change: got rst=%b done=%b cnt=%0d at edge %0d, required no change",
                             bus.rst_stgb, bus.seq_done, bus.ext_rst_cnt, edgeCnt);
                end else begin
                    ev = expQ.pop_front();
                    checkOutput("event_edge", edgeCnt, ev.edgeNum);
                    checkOutput("event_rst_stgb", 32'(bus.rst_stgb), 32'(ev.rst));
                    checkOutput("event_seq_done", 32'(bus.seq_done), 32'(ev.done));
                    checkOutput("event_ext_rst_cnt", 32'(bus.ext_rst_cnt), 32'(ev.cnt));
                end
                pRst  = bus.rst_stgb;
                pDone = bus.seq_done;
                pCnt  = bus.ext_rst_cnt;
            end
        end
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: stuck at edge %0d, required to finish", edgeCnt);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin : stim
        int gl, e, p, kind;
        mRst = '0;  mDone = 1'b0;  mCnt = 0;
        lastRst = '0; lastDone = 1'b0; lastCnt = 0;

        pwup_filt               = 1'b1;
        bus.por_unbuf           = 1'b1;
        bus.por_timed_out       = 1'b0;
        bus.force_short_oneshot = 1'b0;
        bus.ext_rstb            = 1'b1;
        #2 pwup_filt = 1'b0;
        #1;
        checkOutput("reset_rst_stgb", 32'(bus.rst_stgb), 32'd0);
        checkOutput("reset_seq_done", 32'(bus.seq_done), 32'd0);
        checkOutput("reset_ext_rst_cnt", 32'(bus.ext_rst_cnt), 32'd0);
        @(negedge osc_ck);
        pwup_filt = 1'b1;
        waitToEdge(edgeCnt + 20);
        checkOutput("hold_before_go", 32'(bus.rst_stgb), 32'd0);

        $display("[TB] normal release, external abort in DONE, restart");
        applyStimulus(1'b0, K_EXTR, N_STG * GAP + 3);
        $display("[TB] short-gap release");
        applyStimulus(1'b1, K_POR, N_STG * GAP_SHORT + 4);
        $display("[TB] por_timed_out drop with two stages released");
        applyStimulus(1'b0, K_POR, 2 * GAP + 1 + int'($urandom_range(0, GAP - 2)));
        $display("[TB] abort coincident with last release");
        applyStimulus(1'b1, K_POR, N_STG * GAP_SHORT);
        $display("[TB] por_unbuf regression");
        applyStimulus(1'b0, K_UNB, int'($urandom_range(1, N_STG * GAP + 4)));

        $display("[TB] randomized runs");
        for (int r = 0; r < 8; r++) begin
            gl   = ($urandom_range(0, 1) == 1) ? GAP_SHORT : GAP;
            kind = int'($urandom_range(K_POR, K_EXT));
            applyStimulus(gl == GAP_SHORT, kind, int'($urandom_range(1, N_STG * gl + 4)));
        end

        $display("[TB] external aborts up to saturation");
        for (int r = 0; r < 17; r++) begin
            applyStimulus(1'b1, K_EXT, int'($urandom_range(1, N_STG * GAP_SHORT + 2)));
        end
        checkOutput("ext_rst_cnt_saturated", 32'(bus.ext_rst_cnt), 32'd15);

        $display("[TB] asynchronous power-up reset mid-release");
        bus.force_short_oneshot = 1'b0;
        e = edgeCnt + 2;
        p = e + 2 * GAP + 3;
        planSeq(e, GAP, p, 1'b0, 1'b1);
        waitToEdge(e);
        bus.por_timed_out = 1'b1;
        bus.por_unbuf     = 1'b0;
        waitToEdge(p);
        @(posedge osc_ck);
        #3;
        pwup_filt         = 1'b0;
        bus.por_timed_out = 1'b0;
        #1;
        checkOutput("async_rst_stgb", 32'(bus.rst_stgb), 32'd0);
        checkOutput("async_seq_done", 32'(bus.seq_done), 32'd0);
        checkOutput("async_ext_rst_cnt", 32'(bus.ext_rst_cnt), 32'd0);
        repeat (3) @(negedge osc_ck);
        pwup_filt = 1'b1;
        waitToEdge(edgeCnt + 20);
        checkOutput("no_release_without_go", 32'(bus.rst_stgb), 32'd0);
        checkOutput("no_done_without_go", 32'(bus.seq_done), 32'd0);

        waitToEdge(edgeCnt + 3);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
